axis_ask_uart_rx_wrapper: RTL

- Receive-side counterpart of the ASK UART transmit path.
- Slices the multi-level ASK amplitude input into a line bit, then deframes 8N1 UART characters at a fixed bit period.
- Buffers received bytes in a FIFO and presents them as an AXI-Stream master, so downstream AXIS consumers sit directly on it.

---
 rtl/axis_ask_uart_rx_wrapper_pkg.sv | 14 +
 rtl/axis_ask_uart_rx_wrapper_sync_fifo_fwft.sv | 57 +++++
 rtl/axis_ask_uart_rx_wrapper.sv | 138 +++++++++++++
 3 files changed

// File: rtl/axis_ask_uart_rx_wrapper_pkg.sv
// rtl/axis_ask_uart_rx_wrapper_pkg.sv - shared UART framing constants and deframer state encoding
// Shared with the TX side: 8N1 data width and the IDLE/START/DATA/STOP state type.
package axis_ask_uart_rx_wrapper_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/axis_ask_uart_rx_wrapper_sync_fifo_fwft.sv
// rtl/axis_ask_uart_rx_wrapper_sync_fifo_fwft.sv - first-word-fall-through synchronous FIFO
// Ports: clk, rst (sync active-low), push/din write side, pop read side,
//        dout (head word, 0 when empty), empty, full, level (0..DEPTH).
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // When full, a same-cycle pop frees the slot being written (wr_ptr == rd_ptr).
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/axis_ask_uart_rx_wrapper.sv
// rtl/axis_ask_uart_rx_wrapper.sv - ASK slicer, 8N1 deframer and AXIS byte FIFO
// Ports: clk, rst (sync active-low), ask_rx (async amplitude sample),
//        o_tdata/o_tvalid/o_tready AXIS master, fifo_level, frame_err and
//        overrun one-cycle pulses, busy (deframer not idle).
module axis_ask_uart_rx_wrapper
  import axis_ask_uart_rx_wrapper_pkg::*;
#(
  parameter int ask_rx_length = 2,
  parameter int ASK_THRESHOLD = 2,
  parameter int RX_SIZE       = 16,
  parameter int clkdiv_rx     = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ask_rx_length-1:0] ask_rx,
  output logic [7:0]               o_tdata,
  output logic                     o_tvalid,
  input  logic                     o_tready,
  output logic [15:0]              fifo_level,
  output logic                     frame_err,
  output logic                     overrun,
  output logic                     busy
);

  localparam int LW = $clog2(RX_SIZE) + 1;
  localparam logic [ask_rx_length-1:0] THR = ask_rx_length'(ASK_THRESHOLD);
  localparam logic [15:0] HALF_M1 = 16'(clkdiv_rx / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(clkdiv_rx - 1);

  logic                 raw_bit;
  logic                 sync_q;
  logic                 line_bit;
  uart_state_t          state;
  logic [15:0]          cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 push_req;
  logic                 pop;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [LW-1:0]        level_raw;

  assign raw_bit = (ask_rx >= THR);

  // Two-flop synchronizer; resets to the idle (mark) level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q   <= 1'b1;
      line_bit <= 1'b1;
    end else begin
      sync_q   <= raw_bit;
      line_bit <= sync_q;
    end
  end

  assign pop      = o_tvalid & o_tready;
  assign push_req = (state == ST_STOP) && (cnt == '0) && line_bit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      // Only a good stop bit raises push_req, so overrun and frame_err are exclusive.
      overrun   <= push_req & fifo_full & ~pop;
      case (state)
        ST_IDLE: begin
          if (!line_bit) begin
            cnt   <= HALF_M1;
            state <= ST_START;
            busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!line_bit) begin
            cnt     <= FULL_M1;
            bit_idx <= '0;
            state   <= ST_DATA;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            // LSB arrives first, so shift in from the top.
            shreg <= {line_bit, shreg[DATA_BITS-1:1]};
            cnt   <= FULL_M1;
            if (bit_idx == 3'(DATA_BITS - 1)) state <= ST_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            frame_err <= ~line_bit;
            state     <= ST_IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  sync_fifo_fwft #(
    .WIDTH (DATA_BITS),
    .DEPTH (RX_SIZE)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .din   (shreg),
    .pop   (pop),
    .dout  (o_tdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (level_raw)
  );

  assign o_tvalid   = ~fifo_empty;
  assign fifo_level = 16'(level_raw);

endmodule
